// File: rtl/parity_gen_check_if.sv
// parity_gen_check_if: upstream/downstream beat bundle for parity_gen_check.
// slave is the parity block's view, master the view of whoever drives it.
interface parity_gen_check_if #(
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_par;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_par;
    logic              out_err;
    logic              out_frame_par;
    logic              out_frame_err;

    modport slave (
        input  in_valid, in_data, in_par, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_par, out_err,
               out_frame_par, out_frame_err
    );

    modport master (
        output in_valid, in_data, in_par, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_par, out_err,
               out_frame_par, out_frame_err
    );
endinterface

// File: rtl/parity_gen_check.sv
// parity_gen_check: one-stage word/frame parity generator and checker.
// Define PARITY_GEN_CHECK_ERRCNT_EN to build in the saturating word-error counter.
module parity_gen_check #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             odd_mode,
    input  logic             clr_count,
    output logic [CNT_W-1:0] err_count,
    parity_gen_check_if.slave bus
);
    typedef enum logic {IDLE, IN_FRAME} state_t;

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              out_par_q, out_par_d;
    logic              out_err_q, out_err_d;
    logic              frame_par_q, frame_par_d;
    logic              frame_err_q, frame_err_d;
    logic              acc_par_q, acc_par_d;
    logic              acc_err_q, acc_err_d;
    logic              accept, raw_par, word_par, word_err;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign raw_par      = ^bus.in_data;
    assign word_par     = raw_par ^ odd_mode;
    assign word_err     = bus.in_par != word_par;

    // Accumulators track data parity without odd_mode; the last beat's odd_mode is applied once.
    always_comb begin
        out_valid_d = accept ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
        out_data_d  = accept ? bus.in_data : out_data_q;
        out_last_d  = accept ? bus.in_last : out_last_q;
        out_par_d   = accept ? word_par : out_par_q;
        out_err_d   = accept ? word_err : out_err_q;
        frame_par_d = accept ? (bus.in_last & (acc_par_q ^ word_par)) : frame_par_q;
        frame_err_d = accept ? (bus.in_last & (acc_err_q | word_err)) : frame_err_q;
        acc_par_d   = accept ? (!bus.in_last & (acc_par_q ^ raw_par)) : acc_par_q;
        acc_err_d   = accept ? (!bus.in_last & (acc_err_q | word_err)) : acc_err_q;
        state_d     = accept ? (bus.in_last ? IDLE : IN_FRAME) : state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_par_q   <= 1'b0;
            out_err_q   <= 1'b0;
            frame_par_q <= 1'b0;
            frame_err_q <= 1'b0;
            acc_par_q   <= 1'b0;
            acc_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_par_q   <= out_par_d;
            out_err_q   <= out_err_d;
            frame_par_q <= frame_par_d;
            frame_err_q <= frame_err_d;
            acc_par_q   <= acc_par_d;
            acc_err_q   <= acc_err_d;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_last      = out_last_q;
    assign bus.out_par       = out_par_q;
    assign bus.out_err       = out_err_q;
    assign bus.out_frame_par = frame_par_q;
    assign bus.out_frame_err = frame_err_q;

`ifdef PARITY_GEN_CHECK_ERRCNT_EN
    logic [CNT_W-1:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = clr_count ? '0
                    : (accept && word_err && err_count_q != '1) ? err_count_q + 1'b1
                    : err_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_count_q <= '0;
        else        err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`else
    logic unused_clr_count;
    assign unused_clr_count = clr_count;
    assign err_count        = '0;
`endif
endmodule

// File: tb/tb_parity_gen_check.sv
// tb_parity_gen_check: directed vectors with hand-computed parity, frame and counter results.
module tb_parity_gen_check;
`ifdef PARITY_GEN_CHECK_ERRCNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       odd_mode = 1'b0;
    logic       clr_count = 1'b0;
    logic [3:0] err_count;
    int         total = 0;
    int         bad = 0;

    parity_gen_check_if #(.DATA_W(8)) bus ();

    parity_gen_check #(.DATA_W(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .odd_mode  (odd_mode),
        .clr_count (clr_count),
        .err_count (err_count),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic p, input logic l, input logic m);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_par   = p;
        bus.in_last  = l;
        odd_mode     = m;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_par    = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_fpar", bus.out_frame_par, 0);
        check("rst_cnt", err_count, 0);
        check("rst_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        send(8'h07, 1'b1, 1'b1, 1'b0);
        check("even_valid", bus.out_valid, 1);
        check("even_data", bus.out_data, 8'h07);
        check("even_par", bus.out_par, 1);
        check("even_err", bus.out_err, 0);
        check("even_last", bus.out_last, 1);
        check("even_fpar", bus.out_frame_par, 1);
        check("even_ferr", bus.out_frame_err, 0);
        tick();
        check("drop_valid", bus.out_valid, 0);

        send(8'h00, 1'b0, 1'b1, 1'b1);
        check("odd_par", bus.out_par, 1);
        check("odd_err", bus.out_err, 1);
        check("odd_fpar", bus.out_frame_par, 1);
        check("odd_ferr", bus.out_frame_err, 1);
        check("odd_cnt", err_count, CNT_ON ? 1 : 0);

        send(8'hA5, 1'b0, 1'b1, 1'b0);
        bus.out_ready = 1'b0;
        check("stall_err", bus.out_err, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_valid", bus.out_valid, 1);
            check("stall_data", bus.out_data, 8'hA5);
            check("stall_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h3C;
        bus.in_par    = 1'b0;
        bus.in_last   = 1'b1;
        bus.out_ready = 1'b1;
        #1 check("release_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        check("release_valid", bus.out_valid, 1);
        check("release_data", bus.out_data, 8'h3C);

        send(8'h01, 1'b1, 1'b0, 1'b0);
        check("f1_fpar", bus.out_frame_par, 0);
        send(8'h02, 1'b0, 1'b0, 1'b0);
        check("f2_err", bus.out_err, 1);
        check("f2_ferr", bus.out_frame_err, 0);
        send(8'h04, 1'b1, 1'b1, 1'b0);
        check("f3_fpar", bus.out_frame_par, 1);
        check("f3_ferr", bus.out_frame_err, 1);
        check("f3_cnt", err_count, CNT_ON ? 2 : 0);
        send(8'h03, 1'b0, 1'b1, 1'b0);
        check("idle_fpar", bus.out_frame_par, 0);
        check("idle_ferr", bus.out_frame_err, 0);

        send(8'h01, 1'b0, 1'b0, 1'b0);
        send(8'h02, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_err", bus.out_err, 0);
        check("mid_rst_cnt", err_count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(8'h01, 1'b1, 1'b1, 1'b0);
        check("post_rst_fpar", bus.out_frame_par, 1);
        check("post_rst_ferr", bus.out_frame_err, 0);

        for (int i = 0; i < 20; i++) send(8'h00, 1'b1, 1'b0, 1'b0);
        check("sat_cnt", err_count, CNT_ON ? 15 : 0);
        clr_count = 1'b1;
        send(8'h00, 1'b1, 1'b1, 1'b0);
        clr_count = 1'b0;
        check("clr_cnt", err_count, 0);
        check("clr_ferr", bus.out_frame_err, 1);
        send(8'h00, 1'b1, 1'b1, 1'b0);
        check("after_clr_cnt", err_count, CNT_ON ? 1 : 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/parity_gen_check.md
PARITY_GEN_CHECK -- requirements
Module: parity_gen_check

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data word width (>=1).
REQ-002 The block SHALL have parameter CNT_W, default 8, error-counter width (>=1).
REQ-003 The block SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port odd_mode  input  1  0 = even parity, 1 = odd parity; sampled with each accepted beat.
REQ-006 The block SHALL have port in_valid  input  1  upstream beat valid.
REQ-007 The block SHALL have port in_ready  output  1  block can accept a beat.
REQ-008 The block SHALL have port in_data  input  DATA_W  data word.
REQ-009 The block SHALL have port in_par  input  1  received parity bit to check.
REQ-010 The block SHALL have port in_last  input  1  final beat of frame.
REQ-011 The block SHALL have ports out_valid output 1, out_ready input 1, out_data output DATA_W, and out_last output 1, which form the downstream beat.
REQ-012 The block SHALL have port out_par  output  1  generated word parity.
REQ-013 The block SHALL have port out_err  output  1  word parity mismatch.
REQ-014 The block SHALL have port out_frame_par  output  1  frame parity, valid when out_last=1, else 0.
REQ-015 The block SHALL have port out_frame_err  output  1  any word error in frame, valid when out_last=1, else 0.
REQ-016 The block SHALL have port clr_count  input  1  synchronous clear of err_count.
REQ-017 The block SHALL have port err_count  output  CNT_W  saturating word-error count.

Function
REQ-018 A beat SHALL be accepted when in_valid && in_ready in a cycle.
REQ-019 in_ready SHALL be combinational: !out_valid || out_ready.
REQ-020 Latency SHALL be 1 cycle: an accepted beat appears on out_* in the next cycle with out_valid=1.
REQ-021 out_par SHALL be XOR-reduce(in_data) ^ odd_mode; out_err SHALL be (in_par != out_par).
REQ-022 While out_valid && !out_ready, all out_* SHALL hold stable; out_valid SHALL drop after handoff if no new beat is accepted.
REQ-023 Frame FSM SHALL have two states: IDLE (no beat of current frame accepted) and IN_FRAME; IDLE->IN_FRAME on accepted beat with in_last=0; IN_FRAME->IDLE on accepted beat with in_last=1; a last beat in IDLE SHALL be a one-beat frame.
REQ-024 Frame accumulators SHALL XOR word parities and OR word errors per accepted beat; on the last beat out_frame_par = accumulated XOR ^ odd_mode (odd_mode of last beat), out_frame_err = accumulated OR, then accumulators SHALL clear to 0.
REQ-025 err_count SHALL increment by 1 per accepted beat with word error and saturate at 2^CNT_W-1; clr_count SHALL take priority over a simultaneous increment (result 0).

Reset
REQ-026 rst_n=0 SHALL immediately force out_valid, out_data, out_last, out_par, out_err, out_frame_par, out_frame_err, err_count, and the accumulators to 0 and the FSM to IDLE.
REQ-027 Reset mid-frame SHALL discard the partial frame; the first beat after release SHALL start a new frame.

Configuration
REQ-028 Macro PARITY_GEN_CHECK_ERRCNT_EN SHALL compile in the error counter; when undefined, err_count SHALL be tied to 0, clr_count SHALL be ignored, and no counter flops SHALL exist; all other behaviour SHALL be unchanged.

Verification
REQ-029 Even, in_data=0x07, in_par=1, in_last=1 -> next cycle out_par=1, out_err=0, out_frame_par=1, out_frame_err=0.
REQ-030 Odd, in_data=0x00, in_par=0 -> out_par=1, out_err=1, err_count 0->1 (macro defined).
REQ-031 Beat 0xA5 then out_ready=0 for 2 cycles -> out_valid=1, out_data=0xA5 stable, in_ready=0; on release the next beat SHALL be accepted in the same cycle.
REQ-032 Even frame 0x01, 0x02, 0x04(last), beat 2 in_par=0 -> third output out_frame_par=1, out_frame_err=1; FSM back in IDLE.
REQ-033 CNT_W=4, 20 erroneous beats -> err_count=15; clr_count with concurrent error -> 0.
REQ-034 Reset after 2 beats of a frame, then 0x01 last (even) -> out_frame_par=1, out_frame_err reflects that beat only.
